// File: rtl/bcd_display_ctrl.sv
`timescale 1ns/1ps
// bcd_display_ctrl
// Sequential binary-to-BCD converter for the 7-segment display path.
// A value is accepted over in_valid/in_ready. It is converted with shift-add-3
// (double dabble), one bit per clock. The result is held on bcd_out until the
// next conversion finishes, so the decoders never see intermediate digits.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  in_value is valid this cycle
//   in_ready  controller can accept a value (IDLE only)
//   in_value  unsigned binary value, WIDTH bits
//   bcd_out   held BCD result, digit 0 in bits [3:0]
//   done      one-cycle pulse when bcd_out updates
//   busy      conversion in progress (CONV or DONE)
//   ovf       last accepted value exceeded 10^DIGITS-1 (bcd_out saturates to all 9s)
//   blank     per-digit blank mask for the segment decoders
//
// Optional build macro BCD_DISPLAY_LZB_EN enables leading-zero blanking.
// Without it, blank is tied to zero.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// CONV  | one shift-add-3 iteration per cycle, WIDTH cycles
// DONE  | result registered, done pulse, back to IDLE
module bcd_display_ctrl #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_value,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  done,
    output logic                  busy,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    // Number of decimal digits needed for 2^w-1.
    function automatic int calc_digits(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 1;
        for (int i = 0; i < 64; i++) begin
            if (v >= 10) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic longint pow10_m1(input int d);
        longint p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p - 1;
    endfunction

    localparam int          SD_RAW  = calc_digits(WIDTH);
    // Scratch covers the whole WIDTH-bit range so nothing truncates mid-conversion.
    localparam int          SD      = (SD_RAW > DIGITS) ? SD_RAW : DIGITS;
    localparam int          SW      = 4 * SD;
    localparam int          CW      = $clog2(WIDTH + 1);
    localparam logic [63:0] MAX_VAL = 64'(pow10_m1(DIGITS));
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q,    state_d;
    logic [WIDTH-1:0]    shift_q,    shift_d;
    logic [SW-1:0]       scratch_q,  scratch_d;
    logic [CW-1:0]       cnt_q,      cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [4*DIGITS-1:0] bcd_q,      bcd_d;
    logic                ovf_q,      ovf_d;
    logic [SW-1:0]       adj;

    // Add 3 to every scratch digit that is 5 or more before the shift.
    always_comb begin
        adj = scratch_q;
        for (int j = 0; j < SD; j++) begin
            if (scratch_q[4*j +: 4] >= 4'd5) adj[4*j +: 4] = scratch_q[4*j +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shift_d    = in_value;
                    scratch_d  = '0;
                    cnt_d      = CW'(WIDTH);
                    ovf_pend_d = ({{(64-WIDTH){1'b0}}, in_value} > MAX_VAL);
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                // Truncation drops only the top bit, which stays zero because
                // the scratch width covers the full input range.
                scratch_d = SW'({adj, shift_q[WIDTH-1]});
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last iteration: register the result so it appears with DONE.
                    state_d = S_DONE;
                    bcd_d   = ovf_pend_q ? NINES : scratch_d[4*DIGITS-1:0];
                    ovf_d   = ovf_pend_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef BCD_DISPLAY_LZB_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              zero_run;

    // blank[i] is set while every digit from the top down to i is zero.
    // Digit 0 is never blanked, so a value of 0 still shows one "0".
    // A saturated result is all 9s, so it is never blanked.
    always_comb begin
        blank_d  = blank_q;
        zero_run = 1'b1;
        if (state_q == S_CONV && cnt_q == CW'(1)) begin
            blank_d = '0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                zero_run   = zero_run & (bcd_d[4*i +: 4] == 4'd0);
                blank_d[i] = zero_run & ~ovf_pend_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blank_q <= '0;
        else        blank_q <= blank_d;
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign in_ready = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q == S_CONV) || (state_q == S_DONE);
    assign bcd_out  = bcd_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
`timescale 1ns/1ps
module tb_bcd_display_ctrl;

    localparam int WIDTH  = 14;
    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;
    localparam int LAT    = WIDTH + 1;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_value;
    logic [15:0] bcd_out;
    logic        done;
    logic        busy;
    logic        ovf;
    logic [3:0]  blank;

    bcd_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .bcd_out  (bcd_out),
        .done     (done),
        .busy     (busy),
        .ovf      (ovf),
        .blank    (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
        int          at;
    } exp_t;

    exp_t        sbq[$];
    int          total;
    int          bad;
    int          nc;
    logic [15:0] last_bcd;
    logic        last_ovf;
    logic [3:0]  last_blank;

    // Reference: decimal digits by division, saturation above 10^DIGITS-1,
    // blanking as "value has fewer than i+1 decimal digits".
    function automatic exp_t model(input int v, input int at);
        exp_t e;
        int   p;
        e.at    = at;
        e.bcd   = '0;
        e.blank = '0;
        e.ovf   = 1'b0;
        if (v > MAXV) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            p = 1;
            for (int i = 0; i < DIGITS; i++) begin
                e.bcd[4*i +: 4] = 4'((v / p) % 10);
                p = p * 10;
            end
`ifdef BCD_DISPLAY_LZB_EN
            p = 10;
            for (int i = 1; i < DIGITS; i++) begin
                e.blank[i] = (v < p);
                p = p * 10;
            end
`endif
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_bcd   = '0;
            last_ovf   = 1'b0;
            last_blank = '0;
        end else begin
            nc++;
            chk("ready_vs_busy", {31'd0, in_ready}, {31'd0, !busy});
            for (int i = 0; i < DIGITS; i++)
                chk("digit_le9", {31'd0, bcd_out[4*i +: 4] <= 4'd9}, 32'd1);
            if (done) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("bcd_out", {16'd0, bcd_out}, {16'd0, e.bcd});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    chk("blank", {28'd0, blank}, {28'd0, e.blank});
                    chk("done_cycle", nc, e.at);
                end
            end else begin
                chk("bcd_hold", {16'd0, bcd_out}, {16'd0, last_bcd});
                chk("ovf_hold", {31'd0, ovf}, {31'd0, last_ovf});
                chk("blank_hold", {28'd0, blank}, {28'd0, last_blank});
            end
            if (sbq.size() > 0 && nc > sbq[0].at) begin
                chk("done_missing", nc, sbq[0].at);
                void'(sbq.pop_front());
            end
            last_bcd   = bcd_out;
            last_ovf   = ovf;
            last_blank = blank;
        end
    end

    task automatic send(input int v, input bit keep);
        int g;
        g = 0;
        in_value = 14'(v);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 64) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=0 required=1 t=%0t", $time);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sbq.push_back(model(v, nc + LAT));
            #1;
            in_value = 14'($urandom);
            if (!keep) in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int bvals[11] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};

    initial begin
        total    = 0;
        bad      = 0;
        nc       = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {12'd0, bcd_out, done, busy, ovf, blank}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        send(1234, 0);  wait_idle();
        send(0, 0);     wait_idle();
        send(9999, 0);
        send(10000, 0); wait_idle();
        send(5, 1);
        send(6, 1);
        send(7, 0);     wait_idle();

        send(1234, 0);  wait_idle();
        send(4321, 0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {12'd0, bcd_out, done, busy, ovf, blank}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(42, 0);    wait_idle();
        send(16383, 0); wait_idle();

        for (int n = 0; n < 1000; n++) begin
            int v;
            bit keep;
            if ($urandom_range(0, 9) == 0) v = bvals[$urandom_range(0, 10)];
            else                           v = int'($urandom_range(0, 16383));
            keep = ($urandom_range(0, 1) == 1) && (n != 999);
            send(v, keep);
            if (!keep && $urandom_range(0, 7) == 0) wait_idle();
        end
        wait_idle();
        chk("queue_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
